// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared constants, direction type and elaboration helpers
// for the modulo-N event counter (mod_counter / mod_counter_next).
package mod_counter_pkg;

  // Default configuration: a 0..59 seconds counter.
  localparam int MODCNT_DEF_MODULUS = 60;
  localparam int MODCNT_DEF_W       = 6;

  // Count direction. DOWN is only reachable when MODCNT_DOWN_EN is defined.
  typedef enum logic [0:0] {
    UP   = 1'b0,
    DOWN = 1'b1
  } modcnt_dir_t;

  // Number of distinct values a W-bit counter can hold (2^W), widened so that
  // the MODULUS <= 2^W check cannot itself overflow.
  function automatic longint modcnt_capacity(input int w);
    return longint'(64'd1) << w;
  endfunction

  // True when a modulus/width pair describes a buildable counter.
  function automatic bit modcnt_cfg_ok(input int modulus, input int w);
    return (modulus >= 32'sd2) && (longint'(modulus) <= modcnt_capacity(w));
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// mod_counter_next: combinational next-state, terminal-count detect and load
// range check for mod_counter. Holds no state.
// Optional feature macro: MODCNT_DOWN_EN enables the down-count path; without
// it the dn input is ignored and no down-path logic is built.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int MODULUS = MODCNT_DEF_MODULUS,
  parameter int W       = MODCNT_DEF_W
) (
  input  logic [W-1:0] count,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         cnt,
  input  logic         dn,
  output logic [W-1:0] count_next,
  output logic         carry_out,
  output logic         ld_oor
);

  // Terminal value for up counting; a W-bit constant so MODULUS = 2^W still fits.
  localparam logic [W-1:0] TERM_UP = W'(MODULUS - 1);
  // Modulus extended by one bit so it is representable when MODULUS = 2^W.
  localparam logic [W:0]   MOD_EXT = (W+1)'(MODULUS);
  localparam logic [W-1:0] ZERO    = {W{1'b0}};

  logic [W:0]   count_ext;
  logic [W:0]   sum_up;
  logic         at_term_up;
  logic         at_term;
  modcnt_dir_t  dir;

  // Increment is done one bit wider than the counter so it never wraps early.
  assign count_ext  = {1'b0, count};
  assign sum_up     = count_ext + {{W{1'b0}}, 1'b1};
  assign at_term_up = (count == TERM_UP);

  // Load value is legal only below MODULUS; compare in W+1 bits.
  assign ld_oor = ({1'b0, ld_val} >= MOD_EXT);

  // The MSB of the widened increment is always zero whenever it is used
  // (the terminal case wraps to zero instead), so it is only observed here.
  logic unused_sum_msb;
  assign unused_sum_msb = sum_up[W];

`ifdef MODCNT_DOWN_EN
  logic [W:0] diff_dn;
  logic       at_term_dn;
  logic       unused_diff_msb;

  assign dir             = dn ? DOWN : UP;
  assign diff_dn         = count_ext - {{W{1'b0}}, 1'b1};
  assign at_term_dn      = (count == ZERO);
  assign unused_diff_msb = diff_dn[W];
`else
  logic unused_dn;

  assign dir       = UP;
  assign unused_dn = dn;
`endif

  // Select the terminal-count condition for the active direction.
  always_comb begin
    at_term = 1'b0;
    case (dir)
      UP: begin
        at_term = at_term_up;
      end
`ifdef MODCNT_DOWN_EN
      DOWN: begin
        at_term = at_term_dn;
      end
`endif
      default: begin
        at_term = 1'b0;
      end
    endcase
  end

  // Cascade strobe: only a real count step at terminal carries; clear and load
  // both suppress it. Kept free of registers so stages chain in one cycle.
  assign carry_out = cnt & ~clr & ~ld & at_term;

  // Next count with priority clear > load > count > hold.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = ZERO;
    end else if (ld) begin
      if (ld_oor) begin
        count_next = TERM_UP;
      end else begin
        count_next = ld_val;
      end
    end else if (cnt) begin
      case (dir)
        UP: begin
          if (at_term_up) begin
            count_next = ZERO;
          end else begin
            count_next = sum_up[W-1:0];
          end
        end
`ifdef MODCNT_DOWN_EN
        DOWN: begin
          if (at_term_dn) begin
            count_next = TERM_UP;
          end else begin
            count_next = diff_dn[W-1:0];
          end
        end
`endif
        default: begin
          count_next = count;
        end
      endcase
    end else begin
      // No auto-wrap at terminal: an idle counter simply holds.
      count_next = count;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: parametrised modulo-N event counter with synchronous clear,
// range-checked parallel load, registered wrap flag and a combinational
// carry_out for cascading stages (seconds -> minutes -> hours).
// Optional feature macro: MODCNT_DOWN_EN enables down counting via dn.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int MODULUS = MODCNT_DEF_MODULUS,
  parameter int W       = MODCNT_DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         cnt,
  input  logic         dn,
  output logic [W-1:0] count,
  output logic         carry_out,
  output logic         oflow,
  output logic         ld_err
);

  // Reject configurations that cannot be built.
  if (MODULUS < 2) begin : g_chk_modulus_min
    $error("mod_counter: MODULUS must be at least 2");
  end
  if (!modcnt_cfg_ok(MODULUS, W)) begin : g_chk_modulus_fit
    $error("mod_counter: MODULUS must not exceed 2^W");
  end

  logic [W-1:0] count_next;
  logic         ld_oor;
  logic         ld_err_next;

  mod_counter_next #(
    .MODULUS (MODULUS),
    .W       (W)
  ) u_next (
    .count      (count),
    .clr        (clr),
    .ld         (ld),
    .ld_val     (ld_val),
    .cnt        (cnt),
    .dn         (dn),
    .count_next (count_next),
    .carry_out  (carry_out),
    .ld_oor     (ld_oor)
  );

  // Sticky load-error flag: cleared by clr, set by an out-of-range load.
  always_comb begin
    ld_err_next = ld_err;
    if (clr) begin
      ld_err_next = 1'b0;
    end else if (ld && ld_oor) begin
      ld_err_next = 1'b1;
    end else begin
      ld_err_next = ld_err;
    end
  end

  // State registers; rst clears everything immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= {W{1'b0}};
      oflow  <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      count  <= count_next;
      oflow  <= carry_out;
      ld_err <= ld_err_next;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: self-checking bench for mod_counter (60/6) plus a 24/5 stage
// cascaded on its carry_out. Directed table, hand sequences for reset and
// cascade, and randomized stimulus against a behavioural model.
module tb_mod_counter;

  localparam int M  = 60;
  localparam int MH = 24;

  logic       clk = 1'b0;
  logic       rst, clr, ld, cnt, dn;
  logic [5:0] ld_val;
  logic [5:0] count;
  logic       carry_out, oflow, ld_err;
  logic [4:0] hi_count;
  logic       hi_carry, hi_oflow, hi_ld_err;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_count;
  int m_err;

  always #5 clk = ~clk;

  mod_counter #(.MODULUS(M), .W(6)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val), .cnt(cnt), .dn(dn),
    .count(count), .carry_out(carry_out), .oflow(oflow), .ld_err(ld_err)
  );

  mod_counter #(.MODULUS(MH), .W(5)) dut_hi (
    .clk(clk), .rst(rst), .clr(clr), .ld(1'b0), .ld_val(5'd0), .cnt(carry_out), .dn(1'b0),
    .count(hi_count), .carry_out(hi_carry), .oflow(hi_oflow), .ld_err(hi_ld_err)
  );

  typedef struct {
    bit c; bit l; int v; bit e; bit d;
    int x_count; int x_carry; int x_oflow; int x_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; check carry before the edge, registers after it.
  task automatic step(input bit c, input bit l, input int v, input bit e, input bit d,
                      input int x_count, input int x_carry, input int x_oflow,
                      input int x_err, input string tag);
    @(negedge clk);
    clr = c; ld = l; ld_val = v[5:0]; cnt = e; dn = d;
    #1;
    chk({tag, ".carry"}, {31'd0, carry_out}, x_carry);
    @(posedge clk);
    #1;
    chk({tag, ".count"}, {26'd0, count}, x_count);
    chk({tag, ".oflow"}, {31'd0, oflow}, x_oflow);
    chk({tag, ".ld_err"}, {31'd0, ld_err}, x_err);
  endtask

  // Reference: count modulo M, priority clear > load > count.
  task automatic model(input bit c, input bit l, input int v, input bit e, input bit d,
                       output int x_count, output int x_carry, output int x_oflow,
                       output int x_err);
    bit down;
    down = 1'b0;
`ifdef MODCNT_DOWN_EN
    down = d;
`endif
    x_carry = (e && !c && !l && (down ? (m_count == 0) : (m_count == M - 1))) ? 1 : 0;
    if (c) begin
      m_count = 0; m_err = 0;
    end else if (l) begin
      if (v < M) m_count = v;
      else begin m_count = M - 1; m_err = 1; end
    end else if (e) begin
      m_count = down ? (m_count + M - 1) % M : (m_count + 1) % M;
    end
    x_count = m_count;
    x_oflow = x_carry;
    x_err   = m_err;
  endtask

  initial begin
    vec_t vt[$];
    int xc, xk, xo, xe;
    int hi_pulses, lo_pulses;
    bit rc, rl, re, rd;
    int rv;

    rst = 1'b1; clr = 1'b0; ld = 1'b0; cnt = 1'b0; dn = 1'b0; ld_val = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.count", {26'd0, count}, 0);
    chk("reset.oflow", {31'd0, oflow}, 0);
    chk("reset.ld_err", {31'd0, ld_err}, 0);
    @(negedge clk);
    rst = 1'b0;

    //            c  l  v   e  d  count carry oflow err
    vt.push_back('{0, 1, 58, 0, 0, 58, 0, 0, 0});
    vt.push_back('{0, 0, 0,  1, 0, 59, 0, 0, 0});
    vt.push_back('{0, 0, 0,  1, 0, 0,  1, 1, 0});
    vt.push_back('{0, 0, 0,  1, 0, 1,  0, 0, 0});
    vt.push_back('{0, 1, 59, 0, 0, 59, 0, 0, 0});
    for (int i = 0; i < 5; i++) vt.push_back('{0, 0, 0, 0, 0, 59, 0, 0, 0});
    vt.push_back('{0, 1, 45, 0, 0, 45, 0, 0, 0});
    vt.push_back('{0, 1, 63, 0, 0, 59, 0, 0, 1});
    vt.push_back('{0, 0, 0,  1, 0, 0,  1, 1, 1});
    vt.push_back('{0, 0, 0,  1, 0, 1,  0, 0, 1});
    vt.push_back('{1, 0, 0,  1, 0, 0,  0, 0, 0});
    vt.push_back('{0, 1, 59, 0, 0, 59, 0, 0, 0});
    vt.push_back('{1, 1, 10, 1, 0, 0,  0, 0, 0});
    vt.push_back('{0, 1, 60, 0, 0, 59, 0, 0, 1});
    vt.push_back('{0, 1, 59, 1, 0, 59, 0, 0, 1});
    vt.push_back('{1, 0, 0,  0, 0, 0,  0, 0, 0});
    foreach (vt[i])
      step(vt[i].c, vt[i].l, vt[i].v, vt[i].e, vt[i].d,
           vt[i].x_count, vt[i].x_carry, vt[i].x_oflow, vt[i].x_err, $sformatf("vec%0d", i));

    // reset asserted between edges while counting from 37
    step(0, 1, 37, 0, 0, 37, 0, 0, 0, "rst_ld37");
    @(negedge clk);
    ld = 1'b0; cnt = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_mid.count", {26'd0, count}, 0);
    chk("rst_mid.oflow", {31'd0, oflow}, 0);
    @(posedge clk);
    #1;
    chk("rst_hold.count", {26'd0, count}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release.count", {26'd0, count}, 1);

    // reset drops a live oflow pulse and the sticky error
    step(0, 1, 63, 0, 0, 59, 0, 0, 1, "rst_ld63");
    step(0, 0, 0, 1, 0, 0, 1, 1, 1, "rst_wrap");
    @(negedge clk);
    cnt = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_drop.oflow", {31'd0, oflow}, 0);
    chk("rst_drop.ld_err", {31'd0, ld_err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // randomized stimulus against the model
    m_count = 0; m_err = 0;
    model(1, 0, 0, 0, 0, xc, xk, xo, xe);
    step(1, 0, 0, 0, 0, xc, xk, xo, xe, "rnd_sync");
    for (int i = 0; i < 1500; i++) begin
      rc = ($urandom_range(0, 19) == 0);
      rl = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 3) != 0);
      rd = $urandom_range(0, 1);
      rv = $urandom_range(0, 63);
      model(rc, rl, rv, re, rd, xc, xk, xo, xe);
      step(rc, rl, rv, re, rd, xc, xk, xo, xe, "rnd");
    end

    // cascade: 1440 increments of a 60 x 24 timer
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "casc_clr");
    chk("casc_clr.hi", {27'd0, hi_count}, 0);
    hi_pulses = 0; lo_pulses = 0;
    for (int i = 0; i < 1440; i++) begin
      @(negedge clk);
      clr = 1'b0; ld = 1'b0; cnt = 1'b1; dn = 1'b0;
      if (i == 1439) begin
        #1;
        chk("casc_last.hi_carry", {31'd0, hi_carry}, 1);
      end
      @(posedge clk);
      #1;
      if (hi_oflow) hi_pulses++;
      if (oflow) lo_pulses++;
      if (i == 59) chk("casc_60.hi", {27'd0, hi_count}, 1);
    end
    chk("casc_end.lo", {26'd0, count}, 0);
    chk("casc_end.hi", {27'd0, hi_count}, 0);
    chk("casc_end.hi_pulses", hi_pulses, 1);
    chk("casc_end.lo_pulses", lo_pulses, MH);

    // direction from zero
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "dir_clr");
`ifdef MODCNT_DOWN_EN
    step(0, 0, 0, 1, 1, 59, 1, 1, 0, "down_wrap");
    step(0, 0, 0, 1, 1, 58, 0, 0, 0, "down_step");
    step(0, 0, 0, 1, 0, 59, 0, 0, 0, "down_to_up");
`else
    step(0, 0, 0, 1, 1, 1, 0, 0, 0, "dn_ignored");
    step(0, 0, 0, 1, 1, 2, 0, 0, 0, "dn_ignored2");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
